// File: rtl/barrier_sync_master_pkg.sv
// Shared barrier-synchronization types: ACCOUNT/RELEASE messages, counters, tile masks
// and the per-barrier bookkeeping entry used by the sync master.
package barrier_sync_master_pkg;

  localparam int N_TILES               = 16;
  localparam int TILE_ID_W             = $clog2(N_TILES);
  localparam int BARRIER_W             = 8;
  localparam int CNT_W                 = 4;
  localparam int BARRIER_NUMB_FOR_TILE = 8;
  localparam int CENTRAL_SYNCH_ID      = 0;
  localparam bit MANYCORE              = 1'b1;

  typedef logic [TILE_ID_W-1:0] tile_id_t;
  typedef logic [BARRIER_W-1:0] barrier_t;
  typedef logic [CNT_W-1:0]     cnt_barrier_t;
  typedef logic [N_TILES-1:0]   tile_mask_t;

  typedef struct packed {
    tile_id_t     tile_id_source;
    barrier_t     id_barrier;
    cnt_barrier_t cnt_setup;
  } sync_account_message_t;

  typedef struct packed {
    barrier_t id_barrier;
  } sync_release_message_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_COUNTING = 1'b1
  } entry_state_t;

  typedef struct packed {
    entry_state_t state;
    cnt_barrier_t setup;
    cnt_barrier_t arrived;
    tile_mask_t   tile_mask;
    barrier_t     id;
  } barrier_entry_t;

  typedef struct packed {
    barrier_t   id;
    tile_mask_t mask;
  } rel_entry_t;

  // A setup of zero would never complete, so it is treated as a single participant.
  function automatic cnt_barrier_t eff_setup(input cnt_barrier_t c);
    return (c == '0) ? cnt_barrier_t'(1) : c;
  endfunction

  function automatic cnt_barrier_t sat_inc(input cnt_barrier_t c);
    return (&c) ? c : c + cnt_barrier_t'(1);
  endfunction

endpackage

// File: rtl/idx_to_oh.sv
// Binary index to one-hot decoder, purely combinational.
module idx_to_oh #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] oh
);

  always_comb begin
    oh      = '0;
    oh[idx] = 1'b1;
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth; head data is visible combinationally and
// push/pop in the same cycle are allowed. Callers never push when full or pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_vld) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_vld, pop_vld})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);

endmodule

// File: rtl/barrier_sync_master.sv
// Barrier synchronization master: counts ACCOUNT arrivals per barrier entry and queues a
// RELEASE multicast to every accounted tile once the programmed participant count is reached.
module barrier_sync_master
  import barrier_sync_master_pkg::*;
#(
  parameter int TILE_ID        = 0,
  parameter int BARRIER_NUMB   = BARRIER_NUMB_FOR_TILE,
  parameter int REL_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  n2c_account_valid,
  input  sync_account_message_t n2c_account_message,
  output logic                  n2c_mes_service_consumed,
  input  logic                  network_available,
  output logic                  c2n_release_valid,
  output sync_release_message_t c2n_release_message,
  output tile_mask_t            c2n_release_destination_valid
);

  localparam int IDX_W = $clog2(BARRIER_NUMB);

  if (REL_FIFO_DEPTH < 2 || (REL_FIFO_DEPTH & (REL_FIFO_DEPTH - 1)) != 0 ||
      BARRIER_NUMB < 2 || TILE_ID < 0 || TILE_ID >= N_TILES) begin : g_param_err
    $error("barrier_sync_master: illegal parameterization");
  end

  barrier_entry_t entry_q [BARRIER_NUMB];
  barrier_entry_t entry_d [BARRIER_NUMB];
  barrier_entry_t cur_entry;
  barrier_entry_t nxt_entry;

  logic [IDX_W-1:0] entry_idx;
  tile_mask_t       src_oh;
  logic             accept;
  logic             rel_push;
  rel_entry_t       rel_push_dat;
  rel_entry_t       rel_head;
  logic             rel_pop;
  logic             rel_full;
  logic             rel_empty;

  // Upper id bits select the tile in a distributed build and do not address the table.
  assign entry_idx = n2c_account_message.id_barrier[IDX_W-1:0];

  idx_to_oh #(
    .N (N_TILES)
  ) u_src_oh (
    .idx (n2c_account_message.tile_id_source),
    .oh  (src_oh)
  );

  // The NI keeps the message while the release queue is full, even if it pops this cycle.
  assign accept = n2c_account_valid & ~rel_full & ~reset;
  assign n2c_mes_service_consumed = accept;

  always_comb begin
    entry_d      = entry_q;
    cur_entry    = entry_q[entry_idx];
    nxt_entry    = cur_entry;
    rel_push     = 1'b0;
    rel_push_dat = '0;
    if (accept) begin
      if (cur_entry.state == ST_IDLE) begin
        nxt_entry.state     = ST_COUNTING;
        nxt_entry.setup     = eff_setup(n2c_account_message.cnt_setup);
        nxt_entry.arrived   = cnt_barrier_t'(1);
        nxt_entry.tile_mask = src_oh;
        nxt_entry.id        = n2c_account_message.id_barrier;
      end else begin
        nxt_entry.arrived   = sat_inc(cur_entry.arrived);
        nxt_entry.tile_mask = cur_entry.tile_mask | src_oh;
      end
      if (nxt_entry.arrived >= nxt_entry.setup) begin
        rel_push              = 1'b1;
        rel_push_dat.id       = nxt_entry.id;
        rel_push_dat.mask     = nxt_entry.tile_mask;
        nxt_entry.state       = ST_IDLE;
        nxt_entry.arrived     = '0;
        nxt_entry.tile_mask   = '0;
      end
      entry_d[entry_idx] = nxt_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BARRIER_NUMB; i++) entry_q[i] <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(rel_entry_t)),
    .DEPTH (REL_FIFO_DEPTH)
  ) u_rel_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (rel_push),
    .push_dat (rel_push_dat),
    .pop_vld  (rel_pop),
    .pop_dat  (rel_head),
    .full     (rel_full),
    .empty    (rel_empty)
  );

  assign rel_pop           = ~rel_empty & network_available;
  assign c2n_release_valid = rel_pop;

  always_comb begin
    c2n_release_message           = '0;
    c2n_release_destination_valid = '0;
    if (!rel_empty) begin
      c2n_release_message.id_barrier = rel_head.id;
      if (MANYCORE) c2n_release_destination_valid = rel_head.mask;
    end
  end

endmodule

// File: tb/tb_barrier_sync_master.sv
// Self-checking bench: directed scenarios plus random traffic against a per-barrier count model.
module tb_barrier_sync_master;
  import barrier_sync_master_pkg::*;

  localparam int DEPTH = 4;
  localparam int NENT  = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  n2c_account_valid;
  sync_account_message_t n2c_account_message;
  logic                  n2c_mes_service_consumed;
  logic                  network_available;
  logic                  c2n_release_valid;
  sync_release_message_t c2n_release_message;
  tile_mask_t            c2n_release_destination_valid;

  barrier_sync_master #(
    .TILE_ID        (0),
    .BARRIER_NUMB   (NENT),
    .REL_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .n2c_account_valid             (n2c_account_valid),
    .n2c_account_message           (n2c_account_message),
    .n2c_mes_service_consumed      (n2c_mes_service_consumed),
    .network_available             (network_available),
    .c2n_release_valid             (c2n_release_valid),
    .c2n_release_message           (c2n_release_message),
    .c2n_release_destination_valid (c2n_release_destination_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic last_cons = 1'b0;

  typedef struct {
    int         id;
    logic [15:0] mask;
  } rel_t;

  rel_t        exp_q[$];
  int          m_cnt   [NENT];
  int          m_setup [NENT];
  int          m_id    [NENT];
  logic [15:0] m_mask  [NENT];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < NENT; i++) begin
      m_cnt[i] = 0; m_setup[i] = 0; m_id[i] = 0; m_mask[i] = '0;
    end
  endtask

  // Model: expected outputs from queued releases, then advance to the state after the next edge.
  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      last_cons = n2c_mes_service_consumed;
      if (reset) begin
        check("rst_consumed", 32'(n2c_mes_service_consumed), 0);
        check("rst_rel_valid", 32'(c2n_release_valid), 0);
        check("rst_rel_msg", 32'(c2n_release_message.id_barrier), 0);
        check("rst_rel_dest", 32'(c2n_release_destination_valid), 0);
        model_clear();
      end else begin
        bit exp_cons, exp_rel;
        exp_cons = n2c_account_valid && (exp_q.size() < DEPTH);
        exp_rel  = (exp_q.size() > 0) && network_available;
        check("consumed", 32'(n2c_mes_service_consumed), 32'(exp_cons));
        check("rel_valid", 32'(c2n_release_valid), 32'(exp_rel));
        if (exp_rel) begin
          check("rel_id", 32'(c2n_release_message.id_barrier), 32'(exp_q[0].id));
          check("rel_mask", 32'(c2n_release_destination_valid), 32'(exp_q[0].mask));
          void'(exp_q.pop_front());
        end
        if (exp_cons) begin
          int k, s;
          k = int'(n2c_account_message.id_barrier) % NENT;
          s = int'(n2c_account_message.cnt_setup);
          if (m_cnt[k] == 0) begin
            m_setup[k] = (s == 0) ? 1 : s;
            m_id[k]    = int'(n2c_account_message.id_barrier);
          end
          m_cnt[k]  = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
          m_mask[k] = m_mask[k] | (16'h1 << n2c_account_message.tile_id_source);
          if (m_cnt[k] >= m_setup[k]) begin
            exp_q.push_back('{id: m_id[k], mask: m_mask[k]});
            m_cnt[k]  = 0;
            m_mask[k] = '0;
          end
        end
      end
    end
  end

  task automatic send(input int tile, input int id, input int setup);
    bit ok;
    ok = 1'b0;
    n2c_account_valid = 1'b1;
    n2c_account_message.tile_id_source = tile_id_t'(tile);
    n2c_account_message.id_barrier     = barrier_t'(id);
    n2c_account_message.cnt_setup      = cnt_barrier_t'(setup);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n2c_mes_service_consumed) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: id %0d tile %0d never consumed", id, tile);
    end
    @(posedge clk); #1;
    n2c_account_valid = 1'b0;
  endtask

  task automatic expect_rel(input string name, input int id, input int mask);
    @(negedge clk);
    check({name, "_valid"}, 32'(c2n_release_valid), 1);
    check({name, "_id"}, 32'(c2n_release_message.id_barrier), 32'(id));
    check({name, "_mask"}, 32'(c2n_release_destination_valid), 32'(mask));
    @(posedge clk); #1;
  endtask

  task automatic expect_none(input string name);
    @(negedge clk);
    check({name, "_novalid"}, 32'(c2n_release_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    n2c_account_valid = 1'b0;
    n2c_account_message = '0;
    network_available = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) begin @(posedge clk); #1; end

    // Three tiles join barrier 5.
    send(0, 5, 3); send(1, 5, 3); send(2, 5, 3);
    expect_rel("t1", 5, 16'h0007);

    // Zero/one setup completes on the first arrival; the entry re-arms.
    send(3, 2, 0); expect_rel("t2a", 2, 16'h0008);
    send(3, 2, 1); expect_rel("t2b", 2, 16'h0008);
    send(3, 2, 2); expect_none("t2c");
    send(4, 2, 2); expect_rel("t2d", 2, 16'h0018);

    // Interleaved barriers from four threads of tile 1; late setup values are ignored.
    send(1, 1, 2); send(1, 4, 2);
    send(1, 1, 9); expect_rel("t3a", 1, 16'h0002);
    send(1, 4, 9); expect_rel("t3b", 4, 16'h0002);

    // Stalled network: queue fills at four completions and the fifth waits.
    fork
      begin
        for (int i = 0; i < 4; i++) send(i, i, 1);
        n2c_account_valid = 1'b1;
        n2c_account_message.tile_id_source = tile_id_t'(4);
        n2c_account_message.id_barrier     = barrier_t'(4);
        n2c_account_message.cnt_setup      = cnt_barrier_t'(1);
        @(negedge clk);
        check("t4_full_consumed", 32'(n2c_mes_service_consumed), 0);
        @(posedge clk); #1;
        send(4, 4, 1);
      end
      begin
        network_available = 1'b0;
        repeat (20) @(posedge clk);
        #1 network_available = 1'b1;
      end
    join
    repeat (8) begin @(posedge clk); #1; end

    // Reset mid-barrier discards the partial count.
    send(0, 7, 3); send(1, 7, 3);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", 32'(c2n_release_valid), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    send(2, 7, 3); expect_none("t5a");
    send(3, 7, 3); expect_none("t5b");
    send(4, 7, 3); expect_rel("t5c", 7, 16'h001C);

    // Back-to-back epochs on one barrier stay separate.
    send(0, 3, 2); send(1, 3, 2);
    send(2, 3, 2); send(3, 3, 2);
    expect_rel("t6", 3, 16'h000C);

    // Random traffic; an unconsumed message is held until accepted.
    for (int c = 0; c < 2000; c++) begin
      if (!n2c_account_valid || last_cons) begin
        n2c_account_valid = ($urandom_range(0, 99) < 60);
        n2c_account_message.tile_id_source = tile_id_t'($urandom_range(0, N_TILES - 1));
        n2c_account_message.id_barrier     = barrier_t'($urandom_range(0, 255));
        n2c_account_message.cnt_setup      = cnt_barrier_t'($urandom_range(0, 5));
      end
      network_available = ($urandom_range(0, 99) < 70);
      @(posedge clk); #1;
    end
    n2c_account_valid = 1'b0;
    network_available = 1'b1;
    repeat (10) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
